// File: rtl/countdown_timer.sv
// Microwave MM:SS time register: keypad digit shift-in, 1 Hz countdown,
// run/pause/done control, display digits and magnetron enable.
module countdown_timer #(
  parameter int SEC_TENS_WRAP  = 5,
  parameter bit ENTRY_IN_PAUSE = 1'b1
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [3:0] bcd_in_i,
  input  logic       loadn_i,
  input  logic       pgt_1hz_i,
  input  logic       startn_i,
  input  logic       stopn_i,
  input  logic       clearn_i,
  output logic [3:0] sec_ones_o,
  output logic [3:0] sec_tens_o,
  output logic [3:0] min_ones_o,
  output logic [3:0] min_tens_o,
  output logic       mag_on_o,
  output logic       zero_o
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_PAUSE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [3:0] WRAP = 4'(SEC_TENS_WRAP);

  logic [1:0]  state_q, state_d;
  logic [15:0] time_q, time_d;
  logic        loadn_q, pgt_q;

  logic        key, tick, start, stop, clear;
  logic        key_ok, nz;
  logic [3:0]  so, st, mo, mt;
  logic [15:0] dec;
  logic [15:0] shifted;

  assign key    = loadn_q & ~loadn_i;
  assign tick   = ~pgt_q & pgt_1hz_i;
  assign start  = ~startn_i;
  assign stop   = ~stopn_i;
  assign clear  = ~clearn_i;
  assign key_ok = key & (bcd_in_i <= 4'd9);
  assign nz     = |time_q;

  assign {mt, mo, st, so} = time_q;
  assign shifted = {time_q[11:0], bcd_in_i};

  // Borrow chain; minutes stop at 00 rather than wrapping.
  always_comb begin
    dec = time_q;
    if (so != 4'd0) begin
      dec[3:0] = so - 4'd1;
    end else begin
      dec[3:0] = 4'd9;
      if (st != 4'd0) begin
        dec[7:4] = st - 4'd1;
      end else begin
        dec[7:4] = WRAP;
        if (mo != 4'd0) begin
          dec[11:8] = mo - 4'd1;
        end else if (mt != 4'd0) begin
          dec[11:8]  = 4'd9;
          dec[15:12] = mt - 4'd1;
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    time_d  = time_q;
    if (clear) begin
      state_d = S_IDLE;
      time_d  = 16'h0000;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            if (nz && !stop) state_d = S_RUN;
          end else if (key_ok) begin
            time_d = shifted;
          end
        end
        S_RUN: begin
          if (stop) begin
            state_d = S_PAUSE;
          end else if (tick) begin
            time_d = dec;
            if (dec == 16'h0000) state_d = S_DONE;
          end
        end
        S_PAUSE: begin
          if (stop) begin
            state_d = S_PAUSE;
          end else if (start) begin
            if (nz) state_d = S_RUN;
          end else if (ENTRY_IN_PAUSE && key_ok) begin
            time_d = shifted;
          end
        end
        S_DONE: begin
          if (key_ok) begin
            state_d = S_IDLE;
            time_d  = shifted;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      time_q  <= 16'h0000;
      loadn_q <= 1'b1;
      pgt_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      time_q  <= time_d;
      loadn_q <= loadn_i;
      pgt_q   <= pgt_1hz_i;
    end
  end

  assign sec_ones_o = so;
  assign sec_tens_o = st;
  assign min_ones_o = mo;
  assign min_tens_o = mt;
  assign mag_on_o   = (state_q == S_RUN);
  assign zero_o     = ~nz;

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer: per-cycle vector table
// plus a hand-written reset-during-run sequence.
module tb_countdown_timer;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] bcd_in;
  logic       loadn, pgt, startn, stopn, clearn;
  logic [3:0] sec_ones, sec_tens, min_ones, min_tens;
  logic       mag_on, zero;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  countdown_timer dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .bcd_in_i   (bcd_in),
    .loadn_i    (loadn),
    .pgt_1hz_i  (pgt),
    .startn_i   (startn),
    .stopn_i    (stopn),
    .clearn_i   (clearn),
    .sec_ones_o (sec_ones),
    .sec_tens_o (sec_tens),
    .min_ones_o (min_ones),
    .min_tens_o (min_tens),
    .mag_on_o   (mag_on),
    .zero_o     (zero)
  );

  typedef struct {
    logic        rst;
    logic        clearn;
    logic        startn;
    logic        stopn;
    logic        loadn;
    logic        pgt;
    logic [3:0]  bcd;
    logic [15:0] exp_time;
    logic        exp_mag;
    logic        exp_zero;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic r, logic cl, logic st, logic sp,
                              logic ld, logic pg, logic [3:0] b,
                              logic [15:0] t, logic m, logic z);
    vec_t v;
    v.rst = r; v.clearn = cl; v.startn = st; v.stopn = sp;
    v.loadn = ld; v.pgt = pg; v.bcd = b;
    v.exp_time = t; v.exp_mag = m; v.exp_zero = z;
    return v;
  endfunction

  // One clock per vector: drive on negedge, check 1 ns after posedge.
  task automatic run_vec(input vec_t v, input string name);
    logic [17:0] act, exp;
    @(negedge clk);
    rst = v.rst; clearn = v.clearn; startn = v.startn; stopn = v.stopn;
    loadn = v.loadn; pgt = v.pgt; bcd_in = v.bcd;
    @(posedge clk);
    #1;
    act = {min_tens, min_ones, sec_tens, sec_ones, mag_on, zero};
    exp = {v.exp_time, v.exp_mag, v.exp_zero};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h:%h mag=%b zero=%b, expected %h:%h mag=%b zero=%b",
               name, act[17:10], act[9:2], act[1], act[0],
               exp[17:10], exp[9:2], exp[1], exp[0]);
    end
  endtask

  initial begin
    rst = 1'b1; clearn = 1'b1; startn = 1'b1; stopn = 1'b1;
    loadn = 1'b1; pgt = 1'b0; bcd_in = 4'd0;

    //           rst cl st sp ld pg bcd   time     mag zero
    tbl.push_back(mk(1, 1, 1, 1, 1, 0, 0, 16'h0000, 0, 1)); // reset
    tbl.push_back(mk(0, 1, 1, 1, 1, 0, 0, 16'h0000, 0, 1));
    tbl.push_back(mk(0, 1, 1, 1, 0, 0, 1, 16'h0001, 0, 0)); // key 1
    tbl.push_back(mk(0, 1, 1, 1, 1, 0, 0, 16'h0001, 0, 0));
    tbl.push_back(mk(0, 1, 1, 1, 0, 0, 3, 16'h0013, 0, 0)); // key 3
    tbl.push_back(mk(0, 1, 1, 1, 0, 0, 3, 16'h0013, 0, 0)); // held low
    tbl.push_back(mk(0, 1, 1, 1, 1, 0, 0, 16'h0013, 0, 0));
    tbl.push_back(mk(0, 1, 1, 1, 0, 0, 0, 16'h0130, 0, 0)); // key 0
    tbl.push_back(mk(0, 1, 1, 1, 1, 0, 0, 16'h0130, 0, 0));
    tbl.push_back(mk(0, 0, 1, 1, 1, 0, 0, 16'h0000, 0, 1)); // clear
    tbl.push_back(mk(0, 1, 1, 1, 1, 0, 0, 16'h0000, 0, 1));
    tbl.push_back(mk(0, 1, 1, 1, 0, 0, 11, 16'h0000, 0, 1)); // 4'hB
    tbl.push_back(mk(0, 1, 1, 1, 1, 0, 0, 16'h0000, 0, 1));
    tbl.push_back(mk(0, 1, 0, 1, 1, 0, 0, 16'h0000, 0, 1)); // start @0
    tbl.push_back(mk(0, 1, 1, 1, 1, 0, 0, 16'h0000, 0, 1));
    tbl.push_back(mk(0, 1, 1, 1, 0, 0, 2, 16'h0002, 0, 0)); // 00:02
    tbl.push_back(mk(0, 1, 1, 1, 1, 0, 0, 16'h0002, 0, 0));
    tbl.push_back(mk(0, 1, 0, 1, 1, 0, 0, 16'h0002, 1, 0)); // start
    tbl.push_back(mk(0, 1, 1, 1, 1, 0, 0, 16'h0002, 1, 0));
    tbl.push_back(mk(0, 1, 1, 1, 1, 1, 0, 16'h0001, 1, 0)); // tick 1
    tbl.push_back(mk(0, 1, 1, 1, 1, 1, 0, 16'h0001, 1, 0)); // pgt high
    tbl.push_back(mk(0, 1, 1, 1, 1, 0, 0, 16'h0001, 1, 0));
    tbl.push_back(mk(0, 1, 1, 1, 1, 1, 0, 16'h0000, 0, 1)); // tick 2
    tbl.push_back(mk(0, 1, 1, 1, 1, 0, 0, 16'h0000, 0, 1));
    tbl.push_back(mk(0, 1, 1, 1, 1, 1, 0, 16'h0000, 0, 1)); // tick 3
    tbl.push_back(mk(0, 1, 0, 1, 1, 0, 0, 16'h0000, 0, 1)); // start DONE
    tbl.push_back(mk(0, 1, 1, 1, 1, 0, 0, 16'h0000, 0, 1));
    tbl.push_back(mk(0, 1, 1, 1, 0, 0, 7, 16'h0007, 0, 0)); // key DONE
    tbl.push_back(mk(0, 1, 1, 1, 1, 0, 0, 16'h0007, 0, 0));
    tbl.push_back(mk(0, 1, 0, 1, 1, 0, 0, 16'h0007, 1, 0)); // start
    tbl.push_back(mk(0, 1, 1, 1, 1, 0, 0, 16'h0007, 1, 0));
    tbl.push_back(mk(0, 1, 1, 0, 1, 1, 0, 16'h0007, 0, 0)); // stop+tick
    tbl.push_back(mk(0, 1, 1, 1, 1, 1, 0, 16'h0007, 0, 0));
    tbl.push_back(mk(0, 1, 1, 1, 1, 0, 0, 16'h0007, 0, 0));
    tbl.push_back(mk(0, 1, 1, 1, 1, 1, 0, 16'h0007, 0, 0)); // tick PAUSE
    tbl.push_back(mk(0, 1, 1, 1, 0, 1, 2, 16'h0072, 0, 0)); // key PAUSE
    tbl.push_back(mk(0, 1, 1, 1, 1, 1, 0, 16'h0072, 0, 0));
    tbl.push_back(mk(0, 1, 0, 1, 1, 0, 0, 16'h0072, 1, 0)); // resume
    tbl.push_back(mk(0, 1, 1, 1, 1, 1, 0, 16'h0071, 1, 0)); // tick
    tbl.push_back(mk(0, 1, 1, 1, 0, 0, 5, 16'h0071, 1, 0)); // key RUN
    tbl.push_back(mk(0, 1, 1, 1, 1, 0, 0, 16'h0071, 1, 0));
    tbl.push_back(mk(0, 0, 1, 1, 1, 0, 0, 16'h0000, 0, 1)); // clear RUN
    tbl.push_back(mk(0, 1, 1, 1, 1, 0, 0, 16'h0000, 0, 1));
    tbl.push_back(mk(0, 1, 1, 1, 0, 0, 1, 16'h0001, 0, 0)); // 01:00
    tbl.push_back(mk(0, 1, 1, 1, 1, 0, 0, 16'h0001, 0, 0));
    tbl.push_back(mk(0, 1, 1, 1, 0, 0, 0, 16'h0010, 0, 0));
    tbl.push_back(mk(0, 1, 1, 1, 1, 0, 0, 16'h0010, 0, 0));
    tbl.push_back(mk(0, 1, 1, 1, 0, 0, 0, 16'h0100, 0, 0));
    tbl.push_back(mk(0, 1, 1, 1, 1, 0, 0, 16'h0100, 0, 0));
    tbl.push_back(mk(0, 1, 0, 1, 1, 0, 0, 16'h0100, 1, 0));
    tbl.push_back(mk(0, 1, 1, 1, 1, 0, 0, 16'h0100, 1, 0));
    tbl.push_back(mk(0, 1, 1, 1, 1, 1, 0, 16'h0059, 1, 0)); // borrow
    tbl.push_back(mk(0, 0, 1, 1, 1, 0, 0, 16'h0000, 0, 1));
    tbl.push_back(mk(0, 1, 1, 1, 0, 0, 1, 16'h0001, 0, 0)); // 10:00
    tbl.push_back(mk(0, 1, 1, 1, 1, 0, 0, 16'h0001, 0, 0));
    tbl.push_back(mk(0, 1, 1, 1, 0, 0, 0, 16'h0010, 0, 0));
    tbl.push_back(mk(0, 1, 1, 1, 1, 0, 0, 16'h0010, 0, 0));
    tbl.push_back(mk(0, 1, 1, 1, 0, 0, 0, 16'h0100, 0, 0));
    tbl.push_back(mk(0, 1, 1, 1, 1, 0, 0, 16'h0100, 0, 0));
    tbl.push_back(mk(0, 1, 1, 1, 0, 0, 0, 16'h1000, 0, 0));
    tbl.push_back(mk(0, 1, 1, 1, 1, 0, 0, 16'h1000, 0, 0));
    tbl.push_back(mk(0, 1, 0, 1, 1, 0, 0, 16'h1000, 1, 0));
    tbl.push_back(mk(0, 1, 1, 1, 1, 0, 0, 16'h1000, 1, 0));
    tbl.push_back(mk(0, 1, 1, 1, 1, 1, 0, 16'h0959, 1, 0)); // borrow
    tbl.push_back(mk(0, 0, 1, 1, 1, 0, 0, 16'h0000, 0, 1));
    tbl.push_back(mk(0, 1, 1, 1, 0, 0, 5, 16'h0005, 0, 0)); // 05:37
    tbl.push_back(mk(0, 1, 1, 1, 1, 0, 0, 16'h0005, 0, 0));
    tbl.push_back(mk(0, 1, 1, 1, 0, 0, 3, 16'h0053, 0, 0));
    tbl.push_back(mk(0, 1, 1, 1, 1, 0, 0, 16'h0053, 0, 0));
    tbl.push_back(mk(0, 1, 1, 1, 0, 0, 7, 16'h0537, 0, 0));
    tbl.push_back(mk(0, 1, 1, 1, 1, 0, 0, 16'h0537, 0, 0));
    tbl.push_back(mk(0, 1, 0, 1, 1, 0, 0, 16'h0537, 1, 0));
    tbl.push_back(mk(0, 1, 1, 1, 1, 0, 0, 16'h0537, 1, 0));

    foreach (tbl[i]) run_vec(tbl[i], $sformatf("vec%0d", i));

    // Reset mid-RUN at 05:37 with pgt_1hz rising into and held through reset.
    run_vec(mk(1, 1, 1, 1, 1, 1, 0, 16'h0000, 0, 1), "rst_mid_run");
    run_vec(mk(1, 1, 1, 1, 1, 1, 0, 16'h0000, 0, 1), "rst_hold");
    run_vec(mk(0, 1, 1, 1, 1, 1, 0, 16'h0000, 0, 1), "rst_release");
    run_vec(mk(0, 1, 1, 1, 0, 1, 3, 16'h0003, 0, 0), "post_rst_key");
    run_vec(mk(0, 1, 1, 1, 1, 1, 0, 16'h0003, 0, 0), "post_rst_up");
    run_vec(mk(0, 1, 0, 1, 1, 1, 0, 16'h0003, 1, 0), "post_rst_start");
    run_vec(mk(0, 1, 1, 1, 1, 1, 0, 16'h0003, 1, 0), "pgt_high_no_tick");
    run_vec(mk(0, 1, 1, 1, 1, 0, 0, 16'h0003, 1, 0), "pgt_low");
    run_vec(mk(0, 1, 1, 1, 1, 1, 0, 16'h0002, 1, 0), "real_tick");
    // start and key together in IDLE: key dropped, start on current time.
    run_vec(mk(0, 0, 1, 1, 1, 0, 0, 16'h0000, 0, 1), "clear2");
    run_vec(mk(0, 1, 1, 1, 0, 0, 4, 16'h0004, 0, 0), "key4");
    run_vec(mk(0, 1, 1, 1, 1, 0, 0, 16'h0004, 0, 0), "key4_up");
    run_vec(mk(0, 1, 0, 1, 0, 0, 6, 16'h0004, 1, 0), "start_and_key");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
